// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_t;

  function automatic int steps(input int width, input int digit);
    return width / digit;
  endfunction

  // A one-step operation still needs a 1-bit counter to compare against.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_fa_slice.sv
// Combinational ripple chain of DIGIT full adders; also exposes the carry into
// the top bit so the caller can form the signed-overflow flag.
module fa_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic cc;

  always_comb begin
    cc    = ci;
    sum   = '0;
    c_msb = ci;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb  = cc;
      sum[i] = x[i] ^ y[i] ^ cc;
      cc     = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
    end
    co = cc;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock, LSB digit first, with the inter-digit carry held in a register.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; results from last operation held
//   RUN   | one digit per edge; last digit registers s/cout/ovf, done
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = steps(WIDTH, DIGIT);
  localparam int CW    = cnt_w(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_adder: DIGIT must be >= 1 and divide WIDTH");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_co;
  logic             dig_cmsb;
  logic [WIDTH-1:0] res_next;

  fa_slice #(.DIGIT(DIGIT)) u_slice (
    .x     (a_sh[DIGIT-1:0]),
    .y     (b_sh[DIGIT-1:0]),
    .ci    (carry),
    .sum   (dig_sum),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  // New digit enters at the top so after STEPS shifts the LSB digit sits at bit 0.
  assign res_next = (res_sh >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
  assign busy     = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s      <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= sub ? ~b : b;
            carry  <= cin ^ sub;
            cnt    <= '0;
            res_sh <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_next;
          carry  <= dig_co;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            s     <= res_next;
            cout  <= dig_co;
            ovf   <= dig_cmsb ^ dig_co;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder across several WIDTH/DIGIT configurations.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start_v;
  logic [15:0] a16, b16;
  logic        cin_r, sub_r;
  wire  [7:0]  a8 = a16[7:0];
  wire  [7:0]  b8 = b16[7:0];

  wire  [3:0]  busy_v, done_v, cout_v, ovf_v;
  wire  [7:0]  s81, s82, s84;
  wire  [15:0] s164;
  wire  [15:0] s_v [4];

  assign s_v[0] = {8'h00, s81};
  assign s_v[1] = {8'h00, s82};
  assign s_v[2] = s164;
  assign s_v[3] = {8'h00, s84};

  int widths [4] = '{8, 8, 16, 8};
  int steps_of [4] = '{8, 4, 4, 2};

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u81 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a8), .b(b8), .cin(cin_r), .sub(sub_r),
    .busy(busy_v[0]), .done(done_v[0]), .s(s81), .cout(cout_v[0]), .ovf(ovf_v[0]));
  serial_adder #(.WIDTH(8), .DIGIT(2)) u82 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a8), .b(b8), .cin(cin_r), .sub(sub_r),
    .busy(busy_v[1]), .done(done_v[1]), .s(s82), .cout(cout_v[1]), .ovf(ovf_v[1]));
  serial_adder #(.WIDTH(16), .DIGIT(4)) u164 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a16), .b(b16), .cin(cin_r), .sub(sub_r),
    .busy(busy_v[2]), .done(done_v[2]), .s(s164), .cout(cout_v[2]), .ovf(ovf_v[2]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a8), .b(b8), .cin(cin_r), .sub(sub_r),
    .busy(busy_v[3]), .done(done_v[3]), .s(s84), .cout(cout_v[3]), .ovf(ovf_v[3]));

  // Reference: exact integer arithmetic, then reduce to WIDTH bits and flags.
  function automatic void ref_model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                    input logic ci, input logic sb,
                                    output logic [15:0] rs, output logic rc, output logic ro);
    longint m, ua, ub, uc, r, sa, sbv, sr;
    m  = longint'(1) << w;
    ua = longint'(av) & (m - 1);
    ub = longint'(bv) & (m - 1);
    uc = longint'(ci);
    if (!sb) begin
      r  = ua + ub + uc;
      rc = (r >= m);
    end else begin
      r  = ua - ub - uc;
      rc = (r >= 0);
    end
    rs  = 16'(((r % m) + m) % m);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    sr  = sb ? sa - sbv - uc : sa + sbv + uc;
    ro  = (sr < -(m / 2)) || (sr > (m / 2 - 1));
  endfunction

  // Drives one operation and collects outputs at the done pulse (no checking here).
  task automatic run_op(input int idx, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb,
                        output logic [15:0] rs, output logic rc, output logic ro, output int lat);
    @(negedge clk);
    a16 = av; b16 = bv; cin_r = ci; sub_r = sb;
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    cin_r = 1'($urandom); sub_r = 1'($urandom);
    lat = 0;
    while (!done_v[idx] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = s_v[idx]; rc = cout_v[idx]; ro = ovf_v[idx];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({busy_v[i], done_v[i], cout_v[i], ovf_v[i]} !== 4'b0000 || s_v[i] !== 16'h0000) begin
        n_bad++;
        $display("FAIL reset[%0d]: busy=%b done=%b cout=%b ovf=%b s=%h, required all zero",
                 i, busy_v[i], done_v[i], cout_v[i], ovf_v[i], s_v[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_timing();
    int k;
    logic seen_done;
    @(negedge clk);
    a16 = 16'h000F; b16 = 16'h0001; cin_r = 1'b0; sub_r = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    seen_done = 1'b0;
    for (k = 0; k < 8; k++) begin
      n_vec++;
      if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_window k=%0d: busy=%b done=%b, required busy=1 done=0", k, busy_v[0], done_v[0]);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL done_at_8: busy=%b done=%b, required busy=0 done=1", busy_v[0], done_v[0]);
    end
    n_vec++;
    if ({s_v[0], cout_v[0], ovf_v[0]} !== {16'h0010, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL add_0f_01: s=%h cout=%b ovf=%b, required s=10 cout=0 ovf=0", s_v[0], cout_v[0], ovf_v[0]);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done_v[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL done_one_cycle: done=%b, required 0", done_v[0]);
    end
  endtask

  task automatic test_directed();
    logic [15:0] tbl_a [5] = '{16'hFF, 16'h7F, 16'h05, 16'h80, 16'h9C};
    logic [15:0] tbl_b [5] = '{16'h01, 16'h01, 16'h07, 16'h01, 16'h64};
    logic        tbl_sb[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [17:0] tbl_ex[5] = '{{16'h00, 1'b1, 1'b0}, {16'h80, 1'b0, 1'b1}, {16'hFE, 1'b0, 1'b0},
                              {16'h7F, 1'b1, 1'b1}, {16'h00, 1'b1, 1'b0}};
    logic [15:0] rs; logic rc, ro; int lat; int idx;
    for (int i = 0; i < 5; i++) begin
      idx = (i == 4) ? 3 : 0;
      run_op(idx, tbl_a[i], tbl_b[i], 1'b0, tbl_sb[i], rs, rc, ro, lat);
      n_vec++;
      if ({rs, rc, ro} !== tbl_ex[i]) begin
        n_bad++;
        $display("FAIL directed[%0d]: s=%h cout=%b ovf=%b, required s=%h cout=%b ovf=%b",
                 i, rs, rc, ro, tbl_ex[i][17:2], tbl_ex[i][1], tbl_ex[i][0]);
      end
      n_vec++;
      if (lat !== steps_of[idx]) begin
        n_bad++;
        $display("FAIL directed_latency[%0d]: got %0d edges, required %0d", i, lat, steps_of[idx]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int lat, extra;
    @(negedge clk);
    a16 = 16'h12; b16 = 16'h34; cin_r = 1'b0; sub_r = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a16 = 16'h55; b16 = 16'h55; sub_r = 1'b1; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    lat = 4;
    while (!done_v[0] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (lat !== 8 || s_v[0] !== 16'h0046 || cout_v[0] !== 1'b0 || ovf_v[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_busy: lat=%0d s=%h cout=%b ovf=%b, required lat=8 s=46 cout=0 ovf=0",
               lat, s_v[0], cout_v[0], ovf_v[0]);
    end
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) extra++;
    end
    n_vec++;
    if (extra !== 0 || s_v[0] !== 16'h0046) begin
      n_bad++;
      $display("FAIL ignore_no_queue: active cycles=%0d s=%h, required 0 and s=46", extra, s_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rs; logic rc, ro; int lat;
    run_op(0, 16'h30, 16'h0C, 1'b1, 1'b0, rs, rc, ro, lat);
    n_vec++;
    if (rs !== 16'h3D || lat !== 8) begin
      n_bad++;
      $display("FAIL b2b_first: s=%h lat=%0d, required s=3d lat=8", rs, lat);
    end
    // Still inside the done cycle; run_op raises start before the next edge.
    run_op(0, 16'h10, 16'h20, 1'b1, 1'b1, rs, rc, ro, lat);
    n_vec++;
    if (rs !== 16'hEF || rc !== 1'b0 || ro !== 1'b0 || lat !== 8) begin
      n_bad++;
      $display("FAIL b2b_second: s=%h cout=%b ovf=%b lat=%0d, required s=ef cout=0 ovf=0 lat=8",
               rs, rc, ro, lat);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    a16 = 16'h21; b16 = 16'h43; cin_r = 1'b0; sub_r = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy_v[0] !== 1'b0 || s_v[0] !== 16'h0000 || done_v[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b s=%h done=%b, required busy=0 s=0 done=0", busy_v[0], s_v[0], done_v[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_v[0] || busy_v[0]) dones++;
    end
    n_vec++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_no_done: active cycles=%0d, required 0", dones);
    end
  endtask

  task automatic test_random();
    int cfg [3] = '{0, 1, 2};
    logic [15:0] av, bv, rs, es, mask; logic ci, sb, rc, ro, ec, eo; int lat, idx;
    for (int n = 0; n < 1000; n++) begin
      idx  = cfg[n % 3];
      mask = (widths[idx] == 16) ? 16'hFFFF : 16'h00FF;
      av = 16'($urandom) & mask;
      bv = 16'($urandom) & mask;
      ci = 1'($urandom);
      sb = 1'($urandom);
      ref_model(widths[idx], av, bv, ci, sb, es, ec, eo);
      run_op(idx, av, bv, ci, sb, rs, rc, ro, lat);
      n_vec++;
      if (rs !== es || rc !== ec || ro !== eo || lat !== steps_of[idx]) begin
        n_bad++;
        $display("FAIL random[%0d] cfg=%0d a=%h b=%h cin=%b sub=%b: s=%h cout=%b ovf=%b lat=%0d, required s=%h cout=%b ovf=%b lat=%0d",
                 n, idx, av, bv, ci, sb, rs, rc, ro, lat, es, ec, eo, steps_of[idx]);
      end
    end
  endtask

  initial begin
    start_v = 4'b0000;
    a16 = '0; b16 = '0; cin_r = 1'b0; sub_r = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_basic_timing();
    test_directed();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
